// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges load and execute results into one register-file write per cycle.
// Load wins collisions; execute results that lose are parked in a small FIFO that drains ahead of new execute traffic.
module wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [ADDR_WIDTH-1:0] ex_rd,
    input  logic [DATA_WIDTH-1:0] ex_data,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [ADDR_WIDTH-1:0] ld_rd,
    input  logic [2:0]            ld_funct3,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_rd,
    output logic [DATA_WIDTH-1:0] rf_data
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] fifo_rd   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;

    logic                  full, empty;
    logic                  ld_fire, ex_fire;
    logic                  enq, deq;
    logic                  win;
    logic [ADDR_WIDTH-1:0] win_rd;
    logic [DATA_WIDTH-1:0] win_data;
    logic [DATA_WIDTH-1:0] ld_ext;

    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign ex_ready = !full;
    assign ld_ready = !full;
    assign ld_fire  = ld_valid && ld_ready;
    assign ex_fire  = ex_valid && ex_ready;

    // A firing execute request only bypasses the FIFO when nothing else competes.
    assign deq = !ld_fire && !empty;
    assign enq = ex_fire && (ld_fire || !empty);

    always_comb begin
        ld_ext = ld_data;
        case (ld_funct3)
            3'b000: ld_ext = {{(DATA_WIDTH-8){ld_data[7]}}, ld_data[7:0]};
            3'b001: ld_ext = {{(DATA_WIDTH-16){ld_data[15]}}, ld_data[15:0]};
            3'b010: ld_ext = {{(DATA_WIDTH-32){ld_data[31]}}, ld_data[31:0]};
            3'b100: ld_ext = {{(DATA_WIDTH-8){1'b0}}, ld_data[7:0]};
            3'b101: ld_ext = {{(DATA_WIDTH-16){1'b0}}, ld_data[15:0]};
            3'b110: ld_ext = {{(DATA_WIDTH-32){1'b0}}, ld_data[31:0]};
            default: ld_ext = ld_data;
        endcase
    end

    always_comb begin
        win      = 1'b0;
        win_rd   = '0;
        win_data = '0;
        if (ld_fire) begin
            win      = 1'b1;
            win_rd   = ld_rd;
            win_data = ld_ext;
        end else if (!empty) begin
            win      = 1'b1;
            win_rd   = fifo_rd[rd_ptr];
            win_data = fifo_data[rd_ptr];
        end else if (ex_fire) begin
            win      = 1'b1;
            win_rd   = ex_rd;
            win_data = ex_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_rd[wr_ptr]   <= ex_rd;
            fifo_data[wr_ptr] <= ex_data;
        end
    end

    // x0 winners are consumed but never written; rd/data hold across idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen  <= 1'b0;
            rf_rd   <= '0;
            rf_data <= '0;
        end else begin
            rf_wen <= win && (win_rd != '0);
            if (win && (win_rd != '0)) begin
                rf_rd   <= win_rd;
                rf_data <= win_data;
            end
        end
    end

endmodule
